// File: rtl/testchip_testclk_pkg.sv
// Shared types and constants for the test clock source switch controller.
package testchip_testclk_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GATE_OFF = 3'd1,
    SETTLE   = 3'd2,
    GATE_ON  = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam int SETTLE_CNT_W  = 8;
  localparam int TIMEOUT_CNT_W = 12;

  function automatic int sel_width(input int num);
    return (num > 2) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/testchip_testclk_sync.sv
// Two-flop synchroniser bringing the gating-cell acknowledge into the clk domain.
module testchip_testclk_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/testchip_testclk_ctrl.sv
// Glitch-safe test clock source switch: gate off, change mux select, settle, gate back on.
// Optional ack-wait timeout is enabled by defining TESTCHIP_TESTCLK_TIMEOUT_EN.
module testchip_testclk_ctrl
  import testchip_testclk_pkg::*;
#(
  parameter  int NUM_CLK     = 9,
  parameter  int SETTLE_CYC  = 4,
  parameter  int TIMEOUT_CYC = 64,
  localparam int SEL_W       = sel_width(NUM_CLK)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_sel,
  input  logic             req_en,
  output logic             req_ready,
  input  logic             gate_ack,
  output logic             gate_en,
  output logic [SEL_W-1:0] mux_sel,
  output logic             busy,
  output logic             done,
  output logic             err_sel,
  output logic             err_timeout
);

`ifdef TESTCHIP_TESTCLK_TIMEOUT_EN
  localparam int CNT_W = TIMEOUT_CNT_W;
`else
  localparam int CNT_W = SETTLE_CNT_W;
`endif

  if (NUM_CLK < 2 || NUM_CLK > 64 || SETTLE_CYC < 1 || SETTLE_CYC > 255 ||
      TIMEOUT_CYC < 16 || TIMEOUT_CYC > 4095) begin : g_bad_cfg
    $error("testchip_testclk_ctrl: parameter out of range");
  end

  state_e             state_q, state_d;
  logic               gate_en_q, gate_en_d;
  logic [SEL_W-1:0]   mux_sel_q, mux_sel_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               en_q, en_d;
  logic               done_q, done_d;
  logic               err_sel_q, err_sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_sync;
  logic               req_fire;
  logic               sel_bad;
  logic               req_same;
  logic               settle_last;
`ifdef TESTCHIP_TESTCLK_TIMEOUT_EN
  logic               err_to_q, err_to_d;
  logic               timeout_hit;
`endif

  testchip_testclk_sync u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (gate_ack),
    .q     (ack_sync)
  );

  assign req_fire    = req_valid && (state_q == IDLE);
  assign sel_bad     = {1'b0, req_sel} >= (SEL_W + 1)'(NUM_CLK);
  assign req_same    = (req_sel == mux_sel_q) && (req_en == gate_en_q);
  assign settle_last = (cnt_q == CNT_W'(SETTLE_CYC - 1));
`ifdef TESTCHIP_TESTCLK_TIMEOUT_EN
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  // mux_sel only moves on the GATE_OFF exit, where gate_en and the synced ack are both low
  always_comb begin
    state_d   = state_q;
    gate_en_d = gate_en_q;
    mux_sel_d = mux_sel_q;
    sel_d     = sel_q;
    en_d      = en_q;
    done_d    = 1'b0;
    err_sel_d = 1'b0;
    cnt_d     = cnt_q;
`ifdef TESTCHIP_TESTCLK_TIMEOUT_EN
    err_to_d  = err_to_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          if (sel_bad) begin
            err_sel_d = 1'b1;
          end else begin
`ifdef TESTCHIP_TESTCLK_TIMEOUT_EN
            err_to_d = 1'b0;
`endif
            if (req_same) begin
              done_d = 1'b1;
            end else begin
              state_d   = GATE_OFF;
              gate_en_d = 1'b0;
              sel_d     = req_sel;
              en_d      = req_en;
              cnt_d     = '0;
            end
          end
        end
      end
      GATE_OFF: begin
        if (!ack_sync) begin
          state_d   = SETTLE;
          mux_sel_d = sel_q;
          cnt_d     = '0;
        end
`ifdef TESTCHIP_TESTCLK_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d   = IDLE;
          err_to_d  = 1'b1;
          gate_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      SETTLE: begin
        if (settle_last) begin
          state_d   = GATE_ON;
          gate_en_d = en_q;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GATE_ON: begin
        if (!en_q || ack_sync) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
`ifdef TESTCHIP_TESTCLK_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d   = IDLE;
          err_to_d  = 1'b1;
          gate_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      gate_en_q <= 1'b0;
      mux_sel_q <= '0;
      sel_q     <= '0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      err_sel_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gate_en_q <= gate_en_d;
      mux_sel_q <= mux_sel_d;
      sel_q     <= sel_d;
      en_q      <= en_d;
      done_q    <= done_d;
      err_sel_q <= err_sel_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef TESTCHIP_TESTCLK_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_to_q <= 1'b0;
    end else begin
      err_to_q <= err_to_d;
    end
  end

  assign err_timeout = err_to_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign gate_en   = gate_en_q;
  assign mux_sel   = mux_sel_q;
  assign done      = done_q;
  assign err_sel   = err_sel_q;

endmodule

// File: tb/tb_testchip_testclk_ctrl.sv
// Self-checking bench for testchip_testclk_ctrl: directed vector table, reset/timeout
// corner sequences and randomized requests checked against a transaction-level timing model.
module tb_testchip_testclk_ctrl;

  localparam int NUM_CLK    = 9;
  localparam int SETTLE_CYC = 4;
  localparam int SEL_W      = 4;
  // gate_en change -> ack (3) -> synchroniser (2) -> FSM reacts on the following edge (1)
  localparam int ACK_RT     = 6;

  typedef enum int {K_SWITCH, K_NOOP, K_ERR} kind_e;

  typedef struct {
    int    sel;
    bit    en;
    kind_e kind;
    int    k_off;
    int    k_on;
    int    k_done;
    int    mux_after;
    bit    gate_after;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic [SEL_W-1:0] req_sel;
  logic             req_en;
  logic             req_ready;
  logic             gate_ack;
  logic             gate_en;
  logic [SEL_W-1:0] mux_sel;
  logic             busy;
  logic             done;
  logic             err_sel;
  logic             err_timeout;
  logic [2:0]       ack_pipe = 3'b000;
  logic             ack_stuck;

  int     n_cmp;
  int     n_fail;
  longint cyc;
  int     m_mux;
  bit     m_gate;
  longint m_tz;
  bit     m_errto;
  vec_t   vecs[9];

  testchip_testclk_ctrl #(
    .NUM_CLK     (NUM_CLK),
    .SETTLE_CYC  (SETTLE_CYC),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_sel     (req_sel),
    .req_en      (req_en),
    .req_ready   (req_ready),
    .gate_ack    (gate_ack),
    .gate_en     (gate_en),
    .mux_sel     (mux_sel),
    .busy        (busy),
    .done        (done),
    .err_sel     (err_sel),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ack_pipe <= {ack_pipe[1:0], gate_en};
  assign gate_ack = ack_pipe[2] | ack_stuck;

  function automatic logic [9:0] obs();
    return {req_ready, busy, done, gate_en, err_sel, err_timeout, mux_sel};
  endfunction

  function automatic logic [9:0] mk(bit rdy, bit bsy, bit dn, bit ge, bit es, bit et, int mx);
    logic [SEL_W-1:0] m;
    m = SEL_W'(mx);
    return {rdy, bsy, dn, ge, es, et, m};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_output(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s @cyc %0d: got rdy/bsy/dn/ge/es/et/mux=%b expected %b", name, cyc, got, exp);
    end
  endtask

  task automatic predict(input int sel, input bit en, input longint a, output kind_e kind,
                         output int k_off, output int k_on, output int k_done);
    longint tz;
    k_off = 0; k_on = 0; k_done = 0;
    if (sel >= NUM_CLK) begin
      kind = K_ERR;
    end else if (sel == m_mux && en == m_gate) begin
      kind = K_NOOP;
    end else begin
      kind  = K_SWITCH;
      tz    = m_gate ? a : m_tz;
      k_off = (tz + ACK_RT - a > 1) ? int'(tz + ACK_RT - a) : 1;
      k_on  = k_off + SETTLE_CYC;
      k_done = en ? k_on + ACK_RT : k_on + 1;
    end
  endtask

  task automatic apply_stimulus(input string name, input int sel, input bit en, input kind_e kind,
                                input int k_off, input int k_on, input int k_done,
                                input int mux_after, input bit gate_after);
    int     old_mux;
    bit     old_gate;
    longint a;
    logic [9:0] e;
    old_mux  = m_mux;
    old_gate = m_gate;
    req_valid = 1'b1;
    req_sel   = SEL_W'(sel);
    req_en    = en;
    tick();
    a = cyc;
    if (kind == K_SWITCH && m_gate) m_tz = a;
    if (kind != K_ERR) m_errto = 1'b0;
    for (int r = 0; r <= k_done + 1; r++) begin
      if (r > 0) tick();
      case (kind)
        K_SWITCH: e = mk(!(r <= k_done), r <= k_done, r == k_done, gate_after && r >= k_on,
                         1'b0, 1'b0, (r >= k_off) ? mux_after : old_mux);
        K_NOOP:   e = mk(1'b1, 1'b0, r == 0, old_gate, 1'b0, 1'b0, old_mux);
        default:  e = mk(1'b1, 1'b0, 1'b0, old_gate, r == 0, m_errto, old_mux);
      endcase
      check_output(name, obs(), e);
      if (kind == K_SWITCH && r < k_done) begin
        req_valid = 1'($urandom_range(0, 1));
        req_sel   = SEL_W'($urandom_range(0, 15));
        req_en    = 1'($urandom_range(0, 1));
      end else begin
        req_valid = 1'b0;
      end
    end
    m_mux  = mux_after;
    m_gate = gate_after;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    kind_e  kind;
    int     k_off, k_on, k_done, sel, nsel;
    bit     en, saw_done;
    longint a;

    n_cmp = 0; n_fail = 0; cyc = 0;
    m_mux = 0; m_gate = 1'b0; m_tz = -1000; m_errto = 1'b0;
    reset = 1'b1; req_valid = 1'b0; req_sel = '0; req_en = 1'b0; ack_stuck = 1'b0;

    vecs[0] = '{5,  1'b1, K_SWITCH, 1, 5,  11, 5, 1'b1};
    vecs[1] = '{5,  1'b1, K_NOOP,   0, 0,  0,  5, 1'b1};
    vecs[2] = '{12, 1'b0, K_ERR,    0, 0,  0,  5, 1'b1};
    vecs[3] = '{5,  1'b0, K_SWITCH, 6, 10, 11, 5, 1'b0};
    vecs[4] = '{3,  1'b1, K_SWITCH, 1, 5,  11, 3, 1'b1};
    vecs[5] = '{0,  1'b1, K_SWITCH, 6, 10, 16, 0, 1'b1};
    vecs[6] = '{8,  1'b0, K_SWITCH, 6, 10, 11, 8, 1'b0};
    vecs[7] = '{9,  1'b1, K_ERR,    0, 0,  0,  8, 1'b0};
    vecs[8] = '{8,  1'b0, K_NOOP,   0, 0,  0,  8, 1'b0};

    repeat (3) tick();
    check_output("reset_state", obs(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    reset = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 9; i++) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].sel, vecs[i].en, vecs[i].kind,
                     vecs[i].k_off, vecs[i].k_on, vecs[i].k_done,
                     vecs[i].mux_after, vecs[i].gate_after);
      repeat (2) tick();
    end

    // Reset landing in the middle of SETTLE must abort with no done pulse
    predict(4, 1'b1, cyc + 1, kind, k_off, k_on, k_done);
    req_valid = 1'b1; req_sel = SEL_W'(4); req_en = 1'b1;
    tick();
    a = cyc;
    req_valid = 1'b0;
    while (cyc < a + k_off + 2) tick();
    check_output("settle_mux", obs(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4));
    reset = 1'b1;
    #1;
    check_output("reset_async", obs(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    tick();
    check_output("reset_held", obs(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output("post_reset_idle", obs(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    end
    m_mux = 0; m_gate = 1'b0; m_errto = 1'b0;
    repeat (8) tick();

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 3) == 0) begin
        sel = m_mux; en = m_gate;
      end else begin
        sel = int'($urandom_range(0, 11)); en = 1'($urandom_range(0, 1));
      end
      predict(sel, en, cyc + 1, kind, k_off, k_on, k_done);
      apply_stimulus($sformatf("rand%0d", i), sel, en, kind, k_off, k_on, k_done,
                     (kind == K_SWITCH) ? sel : m_mux, (kind == K_SWITCH) ? en : m_gate);
    end

`ifdef TESTCHIP_TESTCLK_TIMEOUT_EN
    // Ack stuck high keeps GATE_OFF waiting until the timeout fires
    ack_stuck = 1'b1;
    repeat (4) tick();
    nsel = (m_mux + 1) % NUM_CLK;
    req_valid = 1'b1; req_sel = SEL_W'(nsel); req_en = 1'b1;
    tick();
    a = cyc;
    req_valid = 1'b0;
    saw_done = done;
    while (cyc < a + 63) begin
      tick();
      saw_done |= done;
    end
    check_output("to_before", obs(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_mux));
    tick();
    saw_done |= done;
    check_output("to_fire", obs(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_mux));
    check_output("to_no_done", {9'd0, saw_done}, 10'd0);
    ack_stuck = 1'b0;
    if (m_gate) m_tz = a;
    m_gate = 1'b0; m_errto = 1'b1;
    repeat (10) tick();
    check_output("to_sticky", obs(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_mux));
    predict(nsel, 1'b1, cyc + 1, kind, k_off, k_on, k_done);
    apply_stimulus("to_clear", nsel, 1'b1, kind, k_off, k_on, k_done, nsel, 1'b1);
`else
    nsel = 0; saw_done = 1'b0;
    check_output("no_timeout_flag", obs() & 10'b0000010000, 10'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
